// File: rtl/axis_stream_sink.sv
// AXI4-Stream receiver: masks and buffers beats in a FWFT FIFO, tracks TLAST framing and
// publishes per-packet byte count / XOR checksum plus running packet and byte totals.
module axis_stream_sink #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]       s_axis_tkeep,
  input  logic                          s_axis_tlast,
  input  logic                          rd_en,
  output logic                          rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_last,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          pkt_done,
  output logic [15:0]                   pkt_bytes,
  output logic [DATA_WIDTH-1:0]         pkt_xsum,
  output logic [CNT_WIDTH-1:0]          pkt_cnt,
  output logic [CNT_WIDTH-1:0]          byte_cnt,
  output logic                          dbg_in_pkt
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int BW = $clog2(KW) + 1;

  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  ready_en_q;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [15:0]           acc_bytes_q, acc_bytes_d;
  logic [DATA_WIDTH-1:0] acc_xsum_q, acc_xsum_d;
  logic                  pkt_done_q, pkt_done_d;
  logic [15:0]           pkt_bytes_q, pkt_bytes_d;
  logic [DATA_WIDTH-1:0] pkt_xsum_q, pkt_xsum_d;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [CNT_WIDTH-1:0]  byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH:0]   mem_q [FIFO_DEPTH];

  logic [DATA_WIDTH-1:0] masked;
  logic [BW-1:0]         beat_bytes;
  logic [16:0]           sum_wide;
  logic [15:0]           sum_bytes;
  logic [DATA_WIDTH-1:0] sum_xsum;
  logic                  push, pop;
  logic [DATA_WIDTH:0]   head;

  // Handshake: a beat transfers on a rising edge with tvalid && tready; tready is a pure
  // function of registers (not of tvalid or rd_en), so a pop while full frees space one cycle later.
  assign s_axis_tready = ready_en_q && (level_q != LW'(FIFO_DEPTH));
  assign push          = s_axis_tvalid && s_axis_tready;
  assign rd_valid      = (level_q != '0);
  assign pop           = rd_en && rd_valid;
  assign head          = mem_q[rd_ptr_q];
  assign rd_data       = rd_valid ? head[DATA_WIDTH-1:0] : '0;
  assign rd_last       = rd_valid && head[DATA_WIDTH];
  assign level         = level_q;
  assign pkt_done      = pkt_done_q;
  assign pkt_bytes     = pkt_bytes_q;
  assign pkt_xsum      = pkt_xsum_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign byte_cnt      = byte_cnt_q;
  assign dbg_in_pkt    = (state_q == IN_PKT);

  always_comb begin
    masked     = '0;
    beat_bytes = '0;
    for (int i = 0; i < KW; i++) begin
      if (s_axis_tkeep[i]) begin
        masked[8*i +: 8] = s_axis_tdata[8*i +: 8];
        beat_bytes       = beat_bytes + BW'(1);
      end
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);
  end

  // Storage carries no reset; rd_valid gates everything read from it.
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= {s_axis_tlast, masked};
  end

  // FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (push) state_d = s_axis_tlast ? IDLE : IN_PKT;
  end

  // FSM outputs: accumulators and completion results
  always_comb begin
    sum_wide    = {1'b0, acc_bytes_q} + 17'(beat_bytes);
    sum_bytes   = (state_q == IDLE) ? 16'(beat_bytes)
                : (sum_wide[16] ? 16'hFFFF : sum_wide[15:0]);
    sum_xsum    = (state_q == IDLE) ? masked : (acc_xsum_q ^ masked);
    acc_bytes_d = acc_bytes_q;
    acc_xsum_d  = acc_xsum_q;
    pkt_done_d  = 1'b0;
    pkt_bytes_d = pkt_bytes_q;
    pkt_xsum_d  = pkt_xsum_q;
    pkt_cnt_d   = pkt_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    if (push) begin
      acc_bytes_d = sum_bytes;
      acc_xsum_d  = sum_xsum;
      byte_cnt_d  = byte_cnt_q + CNT_WIDTH'(beat_bytes);
      if (s_axis_tlast) begin
        pkt_done_d  = 1'b1;
        pkt_bytes_d = sum_bytes;
        pkt_xsum_d  = sum_xsum;
        pkt_cnt_d   = pkt_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_en_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      acc_bytes_q <= '0;
      acc_xsum_q  <= '0;
      pkt_done_q  <= 1'b0;
      pkt_bytes_q <= '0;
      pkt_xsum_q  <= '0;
      pkt_cnt_q   <= '0;
      byte_cnt_q  <= '0;
    end else begin
      ready_en_q  <= 1'b1;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      acc_bytes_q <= acc_bytes_d;
      acc_xsum_q  <= acc_xsum_d;
      pkt_done_q  <= pkt_done_d;
      pkt_bytes_q <= pkt_bytes_d;
      pkt_xsum_q  <= pkt_xsum_d;
      pkt_cnt_q   <= pkt_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
    end
  end

endmodule

// File: tb/tb_axis_stream_sink.sv
// Directed bench for axis_stream_sink: vector table of single beats, then fill, streaming,
// mid-packet reset and a randomised multi-packet run against a scoreboard.
module tb_axis_stream_sink;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        rd_en, rd_valid, rd_last, pkt_done, dbg_in_pkt;
  logic [31:0] rd_data, pkt_xsum, pkt_cnt, byte_cnt;
  logic [4:0]  level;
  logic [15:0] pkt_bytes;

  axis_stream_sink #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .CNT_WIDTH(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .level(level),
    .pkt_done(pkt_done), .pkt_bytes(pkt_bytes), .pkt_xsum(pkt_xsum),
    .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt), .dbg_in_pkt(dbg_in_pkt)
  );

  // clock
  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [31:0] exp_rd;
    int          exp_bb;
    logic [15:0] exp_pkt_bytes;
    logic [31:0] exp_xsum;
  } vec_t;

  vec_t        vecs[9];
  logic [32:0] exp_q[$];
  logic [15:0] pb_q[$];
  logic [31:0] px_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pkt_cnt = 0;
  logic [31:0] exp_byte_cnt = 0;
  logic [31:0] xs;
  logic        drv_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask_fn(input logic [31:0] d, input logic [3:0] k);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (k[i]) m[8*i +: 8] = d[8*i +: 8];
    return m;
  endfunction

  function automatic int bytes_fn(input logic [3:0] k);
    return int'(k[0]) + int'(k[1]) + int'(k[2]) + int'(k[3]);
  endfunction

  task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic l);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
  endtask

  // pops every queued entry, comparing the head before each pop
  task automatic drain(input string name);
    int n;
    n = exp_q.size();
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({name, "_rd"}, {rd_valid, rd_last, rd_data}, {1'b1, exp_q.pop_front()});
      @(negedge aclk);
    end
    rd_en = 1'b0;
    chk({name, "_empty"}, {rd_valid, level}, 6'd0);
  endtask

  initial begin
    vecs[0] = '{32'hA5A51234, 4'b1111, 1'b1, 32'hA5A51234, 4, 16'd4,  32'hA5A51234};
    vecs[1] = '{32'h11111111, 4'b1111, 1'b0, 32'h11111111, 4, 16'd0,  32'h0};
    vecs[2] = '{32'h22222222, 4'b1111, 1'b0, 32'h22222222, 4, 16'd0,  32'h0};
    vecs[3] = '{32'h33333333, 4'b0011, 1'b1, 32'h00003333, 2, 16'd10, 32'h33330000};
    vecs[4] = '{32'hDEADBEEF, 4'b0000, 1'b0, 32'h00000000, 0, 16'd0,  32'h0};
    vecs[5] = '{32'hCAFEF00D, 4'b1010, 1'b1, 32'hCA00F000, 2, 16'd2,  32'hCA00F000};
    vecs[6] = '{32'h12345678, 4'b0100, 1'b1, 32'h00340000, 1, 16'd1,  32'h00340000};
    vecs[7] = '{32'hFFFFFFFF, 4'b1001, 1'b0, 32'hFF0000FF, 2, 16'd0,  32'h0};
    vecs[8] = '{32'h0F0F0F0F, 4'b0110, 1'b1, 32'h000F0F00, 2, 16'd4,  32'hFF0F0FFF};

    // reset
    aresetn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tlast = 1'b0; rd_en = 1'b0;
    repeat (2) @(negedge aclk);
    chk("reset_outputs", {s_axis_tready, rd_valid, rd_last, pkt_done, dbg_in_pkt, level}, 10'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_pkt", {pkt_bytes, pkt_xsum}, 48'd0);
    chk("reset_cnts", {pkt_cnt, byte_cnt}, 64'd0);
    aresetn = 1'b1;
    #1 chk("tready_before_edge", s_axis_tready, 1'b0);
    @(negedge aclk);
    chk("tready_after_edge", s_axis_tready, 1'b1);

    // vector table: one beat at a time, checked then popped
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].data, vecs[i].keep, vecs[i].last);
      @(negedge aclk);
      s_axis_tvalid = 1'b0;
      exp_byte_cnt += 32'(vecs[i].exp_bb);
      if (vecs[i].last) exp_pkt_cnt++;
      chk("vec_head", {rd_valid, rd_last, rd_data}, {1'b1, vecs[i].last, vecs[i].exp_rd});
      chk("vec_level", level, 5'd1);
      chk("vec_done", pkt_done, vecs[i].last);
      chk("vec_cnts", {pkt_cnt, byte_cnt}, {exp_pkt_cnt, exp_byte_cnt});
      chk("vec_fsm", dbg_in_pkt, !vecs[i].last);
      if (vecs[i].last)
        chk("vec_pkt", {pkt_bytes, pkt_xsum}, {vecs[i].exp_pkt_bytes, vecs[i].exp_xsum});
      rd_en = 1'b1;
      @(negedge aclk);
      rd_en = 1'b0;
      chk("vec_pop", {pkt_done, level}, 6'd0);
    end

    // back-to-back single-beat packets
    drive(32'h0000_0001, 4'b1111, 1'b1);
    @(negedge aclk);
    drive(32'h0000_0002, 4'b0011, 1'b1);
    chk("b2b_first", {pkt_done, pkt_bytes, pkt_xsum}, {1'b1, 16'd4, 32'h1});
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    exp_pkt_cnt += 2; exp_byte_cnt += 6;
    chk("b2b_second", {pkt_done, pkt_bytes, pkt_xsum}, {1'b1, 16'd2, 32'h2});
    chk("b2b_cnts", {pkt_cnt, byte_cnt}, {exp_pkt_cnt, exp_byte_cnt});
    @(negedge aclk);
    chk("b2b_done_low", pkt_done, 1'b0);
    exp_q.push_back({1'b1, 32'h1}); exp_q.push_back({1'b1, 32'h2});
    drain("b2b");

    // fill to full, beat 17 held off until one pop frees a slot
    xs = '0;
    for (int i = 0; i < 16; i++) begin
      drive(32'h1000 + 32'(i), 4'b1111, 1'b0);
      exp_q.push_back({1'b0, 32'h1000 + 32'(i)});
      xs ^= 32'h1000 + 32'(i);
      @(negedge aclk);
    end
    drive(32'h2000, 4'b1111, 1'b1);
    chk("fill_full", {s_axis_tready, level}, {1'b0, 5'd16});
    @(negedge aclk);
    chk("fill_held", {s_axis_tready, level}, {1'b0, 5'd16});
    chk("fill_head", {rd_valid, rd_last, rd_data}, {1'b1, exp_q.pop_front()});
    rd_en = 1'b1;
    @(negedge aclk);
    rd_en = 1'b0;
    chk("fill_freed", {s_axis_tready, level}, {1'b1, 5'd15});
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    xs ^= 32'h2000;
    exp_q.push_back({1'b1, 32'h2000});
    exp_pkt_cnt++; exp_byte_cnt += 68;
    chk("fill_refull", {s_axis_tready, level}, {1'b0, 5'd16});
    chk("fill_pkt", {pkt_done, pkt_bytes, pkt_xsum}, {1'b1, 16'd68, xs});
    drain("fill");

    // continuous stream, tvalid and rd_en held high
    xs = '0;
    rd_en = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (rd_valid) chk("stream_rd", {rd_last, rd_data}, exp_q.pop_front());
      chk("stream_level", {s_axis_tready, level <= 5'd1}, 2'b11);
      drive(32'hC000_0000 | 32'(c * 7), 4'b1111, c == 99);
      exp_q.push_back({c == 99, 32'hC000_0000 | 32'(c * 7)});
      xs ^= 32'hC000_0000 | 32'(c * 7);
      @(negedge aclk);
    end
    s_axis_tvalid = 1'b0;
    exp_pkt_cnt++; exp_byte_cnt += 400;
    chk("stream_pkt", {pkt_done, pkt_bytes, pkt_xsum}, {1'b1, 16'd400, xs});
    chk("stream_cnts", {pkt_cnt, byte_cnt}, {exp_pkt_cnt, exp_byte_cnt});
    chk("stream_tail", {rd_valid, rd_last, rd_data}, {1'b1, exp_q.pop_front()});
    @(negedge aclk);
    rd_en = 1'b0;
    chk("stream_empty", {rd_valid, level, 32'(exp_q.size())}, 38'd0);

    // reset in the middle of a packet
    drive(32'hAAAA_0001, 4'b1111, 1'b0);
    @(negedge aclk);
    drive(32'hAAAA_0002, 4'b1111, 1'b0);
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    chk("mid_before", {dbg_in_pkt, level}, {1'b1, 5'd2});
    aresetn = 1'b0;
    #1 chk("mid_async", {s_axis_tready, rd_valid, dbg_in_pkt, level}, 8'd0);
    chk("mid_async_cnts", {pkt_cnt, byte_cnt}, 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("mid_tready", s_axis_tready, 1'b1);
    drive(32'h5555_AAAA, 4'b1111, 1'b1);
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    exp_pkt_cnt = 1; exp_byte_cnt = 4;
    chk("mid_pkt", {pkt_done, pkt_bytes, pkt_xsum}, {1'b1, 16'd4, 32'h5555_AAAA});
    chk("mid_cnts", {pkt_cnt, byte_cnt, level}, {exp_pkt_cnt, exp_byte_cnt, 5'd1});
    exp_q.push_back({1'b1, 32'h5555_AAAA});
    drain("mid");
    rd_en = 1'b1;
    @(negedge aclk);
    rd_en = 1'b0;
    chk("underflow_ignored", {rd_valid, level}, 6'd0);
    drive(32'h0BAD_F00D, 4'b1111, 1'b0);
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    chk("after_underflow", {rd_valid, rd_data, level}, {1'b1, 32'h0BAD_F00D, 5'd1});
    exp_q.push_back({1'b0, 32'h0BAD_F00D});
    exp_byte_cnt += 4;
    drain("uf");

    // random packets with reader stalls
    fork
      begin : driver
        logic [31:0] d, m, px;
        logic [3:0]  k;
        int          len, pb;
        for (int p = 0; p < 30; p++) begin
          len = (p == 0) ? 2 : $urandom_range(1, 5);
          pb = (p == 0) ? 4 : 0;
          px = (p == 0) ? 32'h0BAD_F00D : 32'h0;
          for (int b = 0; b < len; b++) begin
            d = $urandom;
            k = 4'($urandom_range(0, 15));
            m = mask_fn(d, k);
            drive(d, k, b == len - 1);
            for (int t = 0; t < 300 && !s_axis_tready; t++) @(negedge aclk);
            if (!s_axis_tready) chk("rand_accept_timeout", 1'b0, 1'b1);
            exp_q.push_back({b == len - 1, m});
            pb += bytes_fn(k);
            px ^= m;
            exp_byte_cnt += 32'(bytes_fn(k));
            if (b == len - 1) begin
              pb_q.push_back(16'(pb));
              px_q.push_back(px);
              exp_pkt_cnt++;
            end
            @(negedge aclk);
          end
          s_axis_tvalid = 1'b0;
          repeat ($urandom_range(0, 1)) @(negedge aclk);
        end
        drv_done = 1'b1;
      end
      begin : reader
        for (int t = 0; t < 5000; t++) begin
          rd_en = drv_done || ($urandom_range(0, 1) == 1);
          if (rd_en && rd_valid) chk("rand_rd", {rd_last, rd_data}, exp_q.pop_front());
          if (drv_done && exp_q.size() == 0 && !rd_valid) break;
          @(negedge aclk);
        end
        rd_en = 1'b0;
      end
      begin : monitor
        for (int t = 0; t < 5000; t++) begin
          @(negedge aclk);
          if (pkt_done) begin
            if (pb_q.size() == 0) chk("rand_pkt_unexpected", 1'b1, 1'b0);
            else chk("rand_pkt", {pkt_bytes, pkt_xsum}, {pb_q.pop_front(), px_q.pop_front()});
          end
          if (drv_done && pb_q.size() == 0) break;
        end
      end
    join
    // the first random packet continues the open packet started by the 0x0BAD_F00D beat
    chk("rand_pkt_cnt", pkt_cnt, exp_pkt_cnt);
    chk("rand_byte_cnt", byte_cnt, exp_byte_cnt);
    chk("rand_queues_empty", {32'(exp_q.size()), 32'(pb_q.size())}, 64'd0);
    chk("rand_fifo_empty", {rd_valid, level}, 6'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
